// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the six B-type conditions, computes the next-PC target
// and mispredict, holds one result behind valid/ready, and keeps saturating retire counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic             br_less_o,
  output logic             br_equal_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic eq, lt_s, lt_u, less, cond, ill, mis, accept, retire;
  logic [XLEN-1:0] target;

  logic            valid_q, valid_d, taken_q, taken_d, mis_q, mis_d;
  logic            ill_q, ill_d, less_q, less_d, eq_q, eq_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  assign rs1_s = rs1_data_i;
  assign rs2_s = rs2_data_i;

  always_comb begin
    eq   = (rs1_data_i == rs2_data_i);
    lt_s = (rs1_s < rs2_s);
    lt_u = (rs1_data_i < rs2_data_i);
    less = (funct3_i[2:1] == 2'b11) ? lt_u : lt_s;
    ill  = (funct3_i[2:1] == 2'b01);
    case (funct3_i)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
    target = cond ? (pc_i + imm_i) : (pc_i + XLEN'(4));
    mis    = !ill && (cond != pred_taken_i);
  end

  assign in_ready_o = !rst_i && (!valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign retire     = valid_q && out_ready_i && !flush_i;

  always_comb begin
    valid_d   = valid_q;
    taken_d   = taken_q;
    target_d  = target_q;
    mis_d     = mis_q;
    ill_d     = ill_q;
    less_d    = less_q;
    eq_d      = eq_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      taken_d  = cond;
      target_d = target;
      mis_d    = mis;
      ill_d    = ill;
      less_d   = less;
      eq_d     = eq;
    end else if (retire) begin
      valid_d = 1'b0;
    end
    // Counting looks at the result leaving the register, not the one being loaded.
    if (cnt_clr_i) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (retire && !ill_q) begin
      br_cnt_d  = sat_inc(br_cnt_q, 1'b1);
      mis_cnt_d = sat_inc(mis_cnt_q, mis_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      less_q    <= 1'b0;
      eq_q      <= 1'b0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
      less_q    <= less_d;
      eq_q      <= eq_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign taken_o      = taken_q;
  assign target_o     = target_q;
  assign mispredict_o = mis_q;
  assign illegal_o    = ill_q;
  assign br_less_o    = less_q;
  assign br_equal_o   = eq_q;
  assign br_cnt_o     = br_cnt_q;
  assign mis_cnt_o    = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit: a reference model pushes expected results
// into a queue on acceptance; the held result is compared against the queue head each cycle.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mis;
    logic            ill;
    logic            less;
    logic            eq;
  } res_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, pred, clr;
  logic [2:0] f3;
  logic [XLEN-1:0] rs1, rs2, pc, imm;

  logic in_ready, out_valid, taken, mis, ill, less, eq;
  logic [XLEN-1:0] target;
  logic [15:0] br_cnt, mis_cnt;
  logic in_ready2, out_valid2, taken2, mis2, ill2, less2, eq2;
  logic [XLEN-1:0] target2;
  logic [1:0] br_cnt2, mis_cnt2;

  int checks = 0;
  int errors = 0;
  res_t q[$];
  logic m_valid = 1'b0;
  int m_br = 0, m_mis = 0, m_br2 = 0, m_mis2 = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .funct3_i(f3), .rs1_data_i(rs1), .rs2_data_i(rs2), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pred), .out_valid_o(out_valid), .out_ready_i(out_ready), .taken_o(taken),
    .target_o(target), .mispredict_o(mis), .illegal_o(ill), .br_less_o(less),
    .br_equal_o(eq), .cnt_clr_i(clr), .br_cnt_o(br_cnt), .mis_cnt_o(mis_cnt));

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .funct3_i(f3), .rs1_data_i(rs1), .rs2_data_i(rs2), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pred), .out_valid_o(out_valid2), .out_ready_i(out_ready), .taken_o(taken2),
    .target_o(target2), .mispredict_o(mis2), .illegal_o(ill2), .br_less_o(less2),
    .br_equal_o(eq2), .cnt_clr_i(clr), .br_cnt_o(br_cnt2), .mis_cnt_o(mis_cnt2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] fn, input logic [XLEN-1:0] a, b, p, im,
                                 input logic pr);
    res_t r;
    int signed sa, sb;
    logic c;
    sa = a; sb = b;
    r.eq   = (a == b);
    r.ill  = (fn == 3'b010) || (fn == 3'b011);
    r.less = (fn == 3'b110 || fn == 3'b111) ? (a < b) : (sa < sb);
    case (fn)
      3'b000: c = (a == b);
      3'b001: c = (a != b);
      3'b100: c = (sa < sb);
      3'b101: c = (sa >= sb);
      3'b110: c = (a < b);
      3'b111: c = (a >= b);
      default: c = 1'b0;
    endcase
    r.taken  = c;
    r.target = c ? p + im : p + 32'd4;
    r.mis    = r.ill ? 1'b0 : (c != pr);
    return r;
  endfunction

  task automatic cycle(input logic r, fl, v, input logic [2:0] fn,
                       input logic [XLEN-1:0] a, b, p, im, input logic pr, ordy, cl);
    logic exp_rdy, acc, ret;
    res_t head;
    rst = r; flush = fl; in_valid = v; f3 = fn; rs1 = a; rs2 = b; pc = p; imm = im;
    pred = pr; out_ready = ordy; clr = cl;
    #1;
    exp_rdy = !r && (!m_valid || ordy);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    acc = v && exp_rdy && !fl;
    ret = m_valid && ordy && !fl;
    if (ret && q.size() > 0) begin
      head = q[0];
      if (!cl && !head.ill) begin
        m_br++; if (head.mis) m_mis++;
        if (m_br2 < 3) m_br2++;
        if (head.mis && m_mis2 < 3) m_mis2++;
      end
    end
    if (cl) begin m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0; end
    if (r) begin
      m_valid = 1'b0; q.delete(); m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
    end else if (fl) begin
      m_valid = 1'b0; q.delete();
    end else if (acc) begin
      if (m_valid) void'(q.pop_front());
      q.push_back(model(fn, a, b, p, im, pr));
      m_valid = 1'b1;
    end else if (ret) begin
      void'(q.pop_front());
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid && q.size() > 0) begin
      head = q[0];
      chk("taken", {63'd0, taken}, {63'd0, head.taken});
      chk("target", {32'd0, target}, {32'd0, head.target});
      chk("mispredict", {63'd0, mis}, {63'd0, head.mis});
      chk("illegal", {63'd0, ill}, {63'd0, head.ill});
      chk("br_less", {63'd0, less}, {63'd0, head.less});
      chk("br_equal", {63'd0, eq}, {63'd0, head.eq});
    end
    chk("br_cnt", {48'd0, br_cnt}, 64'(m_br));
    chk("mis_cnt", {48'd0, mis_cnt}, 64'(m_mis));
    chk("br_cnt_w2", {62'd0, br_cnt2}, 64'(m_br2));
    chk("mis_cnt_w2", {62'd0, mis_cnt2}, 64'(m_mis2));
  endtask

  task automatic idle(input logic ordy);
    cycle(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, ordy, 0);
  endtask

  initial begin
    // Reset and reset-state of all result outputs.
    cycle(1, 0, 1, 3'b100, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 0, 1, 0);
    cycle(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_taken", {63'd0, taken}, 64'd0);
    chk("rst_target", {32'd0, target}, 64'd0);
    chk("rst_flags", {60'd0, mis, ill, less, eq}, 64'd0);

    // BLT then BLTU with the same operands; BLTU replaces BLT in the same edge.
    cycle(0, 0, 1, 3'b100, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 0, 1, 0);
    chk("blt_target", {32'd0, target}, 64'h120);
    cycle(0, 0, 1, 3'b110, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 0, 1, 0);
    chk("bltu_target", {32'd0, target}, 64'h104);
    idle(1);

    // BEQ held for 3 cycles under backpressure while another op waits.
    cycle(0, 0, 1, 3'b000, 5, 5, 32'h200, 32'h40, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 1, 3'b001, 7, 8, 32'h300, 32'h8, 0, 0, 0);
    chk("held_target", {32'd0, target}, 64'h240);
    idle(1);
    chk("beq_retired", {48'd0, br_cnt}, 64'd3);

    // Four back-to-back BNE ops at full throughput.
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 1, 3'b001, 32'(i), 2, 32'h400 + 32'(4 * i), 32'hFFFF_FFF0, 1, 1, 0);
    idle(1);
    chk("bne_burst", {48'd0, br_cnt}, 64'd7);

    // Flush with a held result and a new op presented.
    cycle(0, 0, 1, 3'b101, 3, 9, 32'h500, 32'h10, 1, 0, 0);
    cycle(0, 1, 1, 3'b000, 1, 1, 32'h600, 32'h10, 0, 1, 0);
    idle(1);

    // Clear, then five mispredicted branches saturate the narrow counters.
    cycle(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 1, 3'b000, 9, 9, 32'h700, 32'h100, 0, 1, 0);
    idle(1);
    chk("sat_br", {62'd0, br_cnt2}, 64'd3);
    chk("sat_mis", {62'd0, mis_cnt2}, 64'd3);

    // Illegal funct3 is reported but not counted.
    cycle(0, 0, 1, 3'b010, 4, 4, 32'hFFFF_FFFC, 32'h20, 1, 1, 0);
    chk("ill_wrap_target", {32'd0, target}, 64'h0);
    cycle(0, 0, 1, 3'b011, 1, 2, 32'h800, 32'h20, 0, 1, 0);
    idle(1);

    // Clear racing a retire, then reset mid-stream.
    cycle(0, 0, 1, 3'b111, 1, 2, 32'h900, 32'h8, 1, 0, 0);
    cycle(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 1, 3'b001, 1, 2, 32'hA00, 32'h8, 1, 0, 0);
    cycle(1, 0, 1, 3'b001, 1, 2, 32'hA00, 32'h8, 1, 0, 0);
    chk("mid_rst_outs", {30'd0, target, taken, mis}, 64'd0);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
            3'($urandom), (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 3)),
            (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
